uart_rx_frame: RTL and testbench

Receive-side frame decoder of the UART core, the counterpart of the transmit path's output-select and shift logic. It synchronises the serial input and detects a start bit. It samples data, optional parity and stop bits at mid-bit on a 16x oversampling tick, then presents the assembled byte with a one-cycle valid pulse and per-frame error flags. It sits between the RX pin and the receive FIFO/register interface.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_frame_if.sv | 16 +
 rtl/rx_sync_edge.sv | 29 ++
 rtl/uart_rx_frame.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: phase codes common to the TX output select and
// the RX frame decoder, plus default frame geometry.
package uart_pkg;

    // STOP..PARITY match the transmitter phase codes; IDLE exists only on RX.
    typedef enum logic [2:0] {
        PH_STOP   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_IDLE   = 3'd4
    } phase_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side result bus: assembled byte, frame-complete strobe, error
// flags and busy indication from the frame decoder to the FIFO/register side.
interface uart_rx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (output rx_data, rx_valid, parity_err, frame_err, rx_busy);
    modport slave  (input  rx_data, rx_valid, parity_err, frame_err, rx_busy);
endinterface

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for an asynchronous, idle-high line plus a third
// flop used to flag a high-to-low transition of the synchronised level.
module rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    // Synchroniser chain; resets to the idle (high) level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign fall = prev & ~sync;
endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame decoder: detects a start edge, samples data, optional
// parity and stop at mid-bit on the oversampling tick, then reports the
// byte with a one-clk valid pulse and per-frame error flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic os_tick,
    input  logic rxd,
    input  logic cfg_parity_en,
    input  logic cfg_parity_odd,
    uart_rx_frame_if.master rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    logic line;
    logic fall;

    phase_t               state,      state_n;
    logic [TW-1:0]        tick_cnt,   tick_n;
    logic [2:0]           bit_cnt,    bit_n;
    logic [DATA_BITS-1:0] shreg,      shreg_n;
    logic                 par_en,     par_en_n;
    logic                 par_odd,    par_odd_n;
    logic                 par_bad,    par_bad_n;
    logic [DATA_BITS-1:0] data_q,     data_n;
    logic                 valid_q,    valid_n;
    logic                 perr_q,     perr_n;
    logic                 ferr_q,     ferr_n;
    logic                 busy_q;

    rx_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rxd),
        .dout (line),
        .fall (fall)
    );

    // State, counters and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PH_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            par_bad  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            par_en   <= par_en_n;
            par_odd  <= par_odd_n;
            par_bad  <= par_bad_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            perr_q   <= perr_n;
            ferr_q   <= ferr_n;
            busy_q   <= (state_n != PH_IDLE);
        end
    end

    // Next-state and datapath decode; all sampling happens only on os_tick.
    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt;
        bit_n     = bit_cnt;
        shreg_n   = shreg;
        par_en_n  = par_en;
        par_odd_n = par_odd;
        par_bad_n = par_bad;
        data_n    = data_q;
        valid_n   = 1'b0;
        perr_n    = perr_q;
        ferr_n    = ferr_q;
        case (state)
            PH_IDLE: begin
                // Only an edge starts a frame, so a stuck-low line stays idle.
                if (fall) begin
                    state_n   = PH_START;
                    tick_n    = '0;
                    bit_n     = '0;
                    par_en_n  = cfg_parity_en;
                    par_odd_n = cfg_parity_odd;
                    par_bad_n = 1'b0;
                end
            end
            PH_START: begin
                if (os_tick) begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_n  = '0;
                        state_n = line ? PH_IDLE : PH_DATA;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            PH_DATA: begin
                if (os_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shreg_n = {line, shreg[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = par_en ? PH_PARITY : PH_STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            PH_PARITY: begin
                if (os_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n    = '0;
                        par_bad_n = line ^ (^shreg) ^ par_odd;
                        state_n   = PH_STOP;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            PH_STOP: begin
                if (os_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        // Return to IDLE at mid-stop so a following start edge is caught.
                        tick_n  = '0;
                        data_n  = shreg;
                        ferr_n  = ~line;
                        perr_n  = par_en & par_bad;
                        valid_n = 1'b1;
                        state_n = PH_IDLE;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            default: state_n = PH_IDLE;
        endcase
    end

    assign rx.rx_data    = data_q;
    assign rx.rx_valid   = valid_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.rx_busy    = busy_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven bit by bit, expected
// results are queued as they are sent and a monitor checks every rx_valid.
module tb_uart_rx_frame;
    localparam int OS = 16;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic os_tick = 1'b1;
    logic rxd = 1'b1;
    logic cfg_parity_en = 1'b0;
    logic cfg_parity_odd = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int n_valid = 0;
    logic prev_valid = 1'b0;
    logic busy_seen = 1'b0;
    exp_t exp_q[$];

    uart_rx_frame_if #(.DATA_BITS(8)) rif ();

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk            (clk),
        .rst            (rst),
        .os_tick        (os_tick),
        .rxd            (rxd),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .rx             (rif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxd = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, input int stop_len);
        drive_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], OS);
        if (pen) drive_bit(pbit, OS);
        drive_bit(stop, stop_len);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        exp_q.push_back(e);
    endtask

    // Monitor: every rx_valid pops one expected frame and compares it.
    always @(negedge clk) begin
        if (!rst && rif.rx_valid) begin
            exp_t e;
            n_valid++;
            check("valid_one_clk", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got data 0x%0h, expected no frame", rif.rx_data);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", 32'(rif.rx_data), 32'(e.data));
                check("parity_err", 32'(rif.parity_err), 32'(e.perr));
                check("frame_err", 32'(rif.frame_err), 32'(e.ferr));
            end
        end
        prev_valid = rif.rx_valid;
        if (rif.rx_busy) busy_seen = 1'b1;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv;
        // Reset state.
        repeat (4) @(negedge clk);
        check("rst_data", 32'(rif.rx_data), 32'd0);
        check("rst_valid", 32'(rif.rx_valid), 32'd0);
        check("rst_busy", 32'(rif.rx_busy), 32'd0);
        check("rst_ferr", 32'(rif.frame_err), 32'd0);
        rst = 1'b0;
        drive_bit(1'b1, 8);

        // 8N1 0xA5.
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, OS);
        drive_bit(1'b1, 8);

        // 8E1 0x37: five ones, so correct even parity bit is 1.
        cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b0;
        expect_frame(8'h37, 1'b0, 1'b0);
        send_frame(8'h37, 1'b1, 1'b1, 1'b1, OS);
        drive_bit(1'b1, 8);
        expect_frame(8'h37, 1'b1, 1'b0);
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, OS);
        drive_bit(1'b1, 8);
        // 8O1 0x37: correct odd parity bit is 0.
        cfg_parity_odd = 1'b1;
        expect_frame(8'h37, 1'b0, 1'b0);
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, OS);
        drive_bit(1'b1, 8);
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;

        // Stop bit low, then line stays low: exactly one frame.
        expect_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, OS);
        drive_bit(1'b0, 5 * OS);
        drive_bit(1'b1, 2 * OS);

        // Glitch: 4 ticks low is a false start.
        nv = n_valid;
        busy_seen = 1'b0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * OS);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_low", 32'(rif.rx_busy), 32'd0);
        check("glitch_no_valid", 32'(n_valid), 32'(nv));

        // Back-to-back frames with a one-bit stop.
        expect_frame(8'h01, 1'b0, 1'b0);
        expect_frame(8'hFE, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, OS);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, OS);
        drive_bit(1'b1, 8);

        // Reset during DATA of 0xC3 (start + bits 1,1,0), then 0x3C.
        drive_bit(1'b0, OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b0, OS / 2);
        @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        check("midrst_data", 32'(rif.rx_data), 32'd0);
        check("midrst_valid", 32'(rif.rx_valid), 32'd0);
        check("midrst_busy", 32'(rif.rx_busy), 32'd0);
        check("midrst_perr", 32'(rif.parity_err), 32'd0);
        check("midrst_ferr", 32'(rif.frame_err), 32'd0);
        rst = 1'b0;
        drive_bit(1'b1, 12 * OS);
        expect_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, OS);
        drive_bit(1'b1, 2 * OS);

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        check("total_valids", 32'(n_valid), 32'd8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
